// File: rtl/int_dispatch_queue_pkg.sv
// Shared core definitions for the integer dispatch queue: the dispatch entry
// format, issue-queue identifiers and the rename width.
package int_dispatch_queue_pkg;

    localparam int RENAME_WIDTH = 4;

    localparam logic [1:0] ALUIQ_ID = 2'd0;
    localparam logic [1:0] MDUIQ_ID = 2'd1;

    typedef struct packed {
        logic [1:0]  dispRS_id;
        logic [6:0]  rob_idx;
        logic [6:0]  prd;
        logic [6:0]  prs1;
        logic [6:0]  prs2;
        logic [4:0]  fu_op;
        logic        imm_vld;
        logic [19:0] imm;
    } intDQEntry_t;

    // Any id other than the ALU queue is steered to the MDU queue.
    function automatic logic is_alu_entry(input intDQEntry_t e);
        return (e.dispRS_id == ALUIQ_ID);
    endfunction

endpackage

// File: rtl/dq_issue_select.sv
// In-order head scan of the dispatch queue: checks per-IQ credits and packs
// the issuing entries onto the ALU and MDU issue ports in age order.
module dq_issue_select
    import int_dispatch_queue_pkg::*;
#(
    parameter int DEQ_WIDTH = 3,
    parameter int ALU_PORTS = 2,
    parameter int MDU_PORTS = 1,
    localparam int SCAN_W   = $clog2(DEQ_WIDTH + 1),
    localparam int AFREE_W  = $clog2(ALU_PORTS + 1),
    localparam int MFREE_W  = $clog2(MDU_PORTS + 1)
) (
    input  intDQEntry_t          scan_info [DEQ_WIDTH],
    input  logic [SCAN_W-1:0]    scan_num,
    input  logic                 squash,
    input  logic [AFREE_W-1:0]   alu_free,
    input  logic [MFREE_W-1:0]   mdu_free,
    output logic [ALU_PORTS-1:0] alu_vld,
    output intDQEntry_t          alu_info [ALU_PORTS],
    output logic [MDU_PORTS-1:0] mdu_vld,
    output intDQEntry_t          mdu_info [MDU_PORTS],
    output logic [SCAN_W-1:0]    deq_num
);

    int   alu_used;
    int   mdu_used;
    int   alu_cap;
    int   mdu_cap;
    logic stop;

    // The first entry that cannot get a slot blocks everything younger.
    always_comb begin
        alu_vld  = '0;
        mdu_vld  = '0;
        for (int p = 0; p < ALU_PORTS; p++) alu_info[p] = '0;
        for (int p = 0; p < MDU_PORTS; p++) mdu_info[p] = '0;
        alu_used = 0;
        mdu_used = 0;
        stop     = 1'b0;
        alu_cap  = (int'(alu_free) < ALU_PORTS) ? int'(alu_free) : ALU_PORTS;
        mdu_cap  = (int'(mdu_free) < MDU_PORTS) ? int'(mdu_free) : MDU_PORTS;

        for (int j = 0; j < DEQ_WIDTH; j++) begin
            if (!stop && !squash && (j < int'(scan_num))) begin
                if (is_alu_entry(scan_info[j])) begin
                    if (alu_used < alu_cap) begin
                        for (int p = 0; p < ALU_PORTS; p++) begin
                            if (p == alu_used) begin
                                alu_vld[p]  = 1'b1;
                                alu_info[p] = scan_info[j];
                            end
                        end
                        alu_used = alu_used + 1;
                    end else begin
                        stop = 1'b1;
                    end
                end else begin
                    if (mdu_used < mdu_cap) begin
                        for (int p = 0; p < MDU_PORTS; p++) begin
                            if (p == mdu_used) begin
                                mdu_vld[p]  = 1'b1;
                                mdu_info[p] = scan_info[j];
                            end
                        end
                        mdu_used = mdu_used + 1;
                    end else begin
                        stop = 1'b1;
                    end
                end
            end
        end

        deq_num = SCAN_W'(alu_used + mdu_used);
    end

endmodule

// File: rtl/int_dispatch_queue.sv
// Integer dispatch queue: circular buffer between dispatch and the ALU/MDU
// issue queues with in-order, credit-limited drain and whole-queue squash.
module int_dispatch_queue
    import int_dispatch_queue_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int INPORT_NUM = RENAME_WIDTH,
    parameter int ALU_PORTS  = 2,
    parameter int MDU_PORTS  = 1,
    parameter int DEQ_WIDTH  = 3,
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int AFREE_W   = $clog2(ALU_PORTS + 1),
    localparam int MFREE_W   = $clog2(MDU_PORTS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_squash_vld,
    output logic                 o_can_enq,
    input  logic [INPORT_NUM-1:0] i_enq_vld,
    input  intDQEntry_t          i_enq_info [INPORT_NUM],
    input  logic [AFREE_W-1:0]   i_aluIQ_free,
    output logic [ALU_PORTS-1:0] o_aluIQ_vld,
    output intDQEntry_t          o_aluIQ_info [ALU_PORTS],
    input  logic [MFREE_W-1:0]   i_mduIQ_free,
    output logic [MDU_PORTS-1:0] o_mduIQ_vld,
    output intDQEntry_t          o_mduIQ_info [MDU_PORTS],
    output logic [CNT_W-1:0]     o_count
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENQ_W  = $clog2(INPORT_NUM + 1);
    localparam int SCAN_W = $clog2(DEQ_WIDTH + 1);
    localparam logic [PTR_W:0] DEPTH_EXT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;
    intDQEntry_t       entries [DEPTH];

    logic [ENQ_W-1:0]  enq_num;
    logic [SCAN_W-1:0] deq_num;
    logic [SCAN_W-1:0] scan_num;
    logic [PTR_W-1:0]  wr_idx [INPORT_NUM];
    intDQEntry_t       scan_info [DEQ_WIDTH];

    // Offsets never exceed DEPTH-1, so one conditional subtract wraps.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W:0]   off);
        logic [PTR_W:0] s;
        s = {1'b0, base} + off;
        if (s >= DEPTH_EXT) s = s - DEPTH_EXT;
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        enq_num = '0;
        for (int k = 0; k < INPORT_NUM; k++) begin
            if (i_enq_vld[k]) enq_num = enq_num + ENQ_W'(1);
            wr_idx[k] = wrap_add(tail_ptr, (PTR_W + 1)'(k));
        end
    end

    always_comb begin
        for (int j = 0; j < DEQ_WIDTH; j++) begin
            scan_info[j] = entries[wrap_add(head_ptr, (PTR_W + 1)'(j))];
        end
        scan_num = (count < CNT_W'(DEQ_WIDTH)) ? SCAN_W'(count) : SCAN_W'(DEQ_WIDTH);
    end

    dq_issue_select #(
        .DEQ_WIDTH (DEQ_WIDTH),
        .ALU_PORTS (ALU_PORTS),
        .MDU_PORTS (MDU_PORTS)
    ) u_select (
        .scan_info (scan_info),
        .scan_num  (scan_num),
        .squash    (i_squash_vld),
        .alu_free  (i_aluIQ_free),
        .mdu_free  (i_mduIQ_free),
        .alu_vld   (o_aluIQ_vld),
        .alu_info  (o_aluIQ_info),
        .mdu_vld   (o_mduIQ_vld),
        .mdu_info  (o_mduIQ_info),
        .deq_num   (deq_num)
    );

    assign o_can_enq = ((CNT_W'(DEPTH) - count) >= CNT_W'(INPORT_NUM));
    assign o_count   = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (i_squash_vld) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= wrap_add(head_ptr, (PTR_W + 1)'(deq_num));
            tail_ptr <= wrap_add(tail_ptr, (PTR_W + 1)'(enq_num));
            count    <= count + CNT_W'(enq_num) - CNT_W'(deq_num);
        end
    end

    // Payload storage is left unreset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < INPORT_NUM; k++) begin
            if (!i_squash_vld && i_enq_vld[k]) begin
                entries[wr_idx[k]] <= i_enq_info[k];
            end
        end
    end

    enq_packed_a: assert property (@(posedge clk) disable iff (rst)
        ((i_enq_vld & (i_enq_vld + INPORT_NUM'(1))) == '0));

    enq_overflow_a: assert property (@(posedge clk) disable iff (rst)
        ((|i_enq_vld) && !i_squash_vld) |-> o_can_enq);

endmodule
